// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type, counter width and id width helper for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int BEAT_CNT_W = 8;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority search; the first set request at or after i_ptr wins
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_hit,
  output logic [ID_W-1:0]  o_idx
);

  localparam logic [ID_W:0] NREQ_L = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_rot;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_sum;

  // Doubling the vector turns the wrap-around into a plain right shift.
  assign w_rot = {i_req, i_req} >> i_ptr;

  always_comb begin
    o_hit = 1'b0;
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_hit = 1'b1;
        w_off = ID_W'(k);
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= NREQ_L) ? ID_W'(w_sum - NREQ_L) : ID_W'(w_sum);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter locking one FIFO write port to a producer per packet
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int FIFO_WIDTH = 8,
  parameter  int MAX_BEATS  = 8,
  localparam int ID_W       = id_width(N_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_last,
  input  logic [N_REQ*FIFO_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_wenable,
  output logic [FIFO_WIDTH-1:0]       o_fifo_wdata,
  output logic [ID_W-1:0]             o_grant_id,
  output logic                        o_busy
);

  localparam logic [BEAT_CNT_W-1:0] MAX_L   = BEAT_CNT_W'(MAX_BEATS);
  localparam logic [ID_W-1:0]       LAST_ID = ID_W'(N_REQ - 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic                  w_pick_hit;
  logic [ID_W-1:0]       w_pick_idx;
  logic                  w_xfer;
  logic                  w_release;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_hit (w_pick_hit),
    .o_idx (w_pick_idx)
  );

  // Full gates ready and wenable combinationally so a blocked beat stays at its producer.
  always_comb begin
    w_state_nxt  = r_state;
    o_req_ready  = '0;
    o_fifo_wdata = '0;
    w_xfer       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_hit) w_state_nxt = ARB_LOCK;
      end
      ARB_LOCK: begin
        o_req_ready[r_grant_id] = !i_fifo_full;
        o_fifo_wdata = i_req_data[r_grant_id*FIFO_WIDTH +: FIFO_WIDTH];
        w_xfer       = i_req_valid[r_grant_id] && !i_fifo_full;
        w_release    = w_xfer && (i_req_last[r_grant_id] || (r_beat_cnt + 1'b1 == MAX_L));
        if (w_release) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_pick_hit) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end
      if (w_xfer) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_release) r_rr_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
    end
  end

  assign o_fifo_wenable = w_xfer;
  assign o_grant_id     = r_grant_id;
  assign o_busy         = (r_state == ARB_LOCK);

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one `fifo` write port between `N_REQ` producers. Each producer offers packets over a valid/ready handshake. The arbiter locks the FIFO write port to one producer for a whole packet, delimited by `last` or by a beat limit. It drives `wenable`/`wdata` directly into the FIFO and never writes while `full` is high. The arbiter sits between the producer blocks and the FIFO instance; the read side of the FIFO is untouched.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `FIFO_WIDTH`, 8, data width; must equal the FIFO's `FIFO_WIDTH`
- `MAX_BEATS`, 8, maximum beats per grant before forced release (1..255)
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req_valid`  in  N_REQ  per-requester beat valid
- `req_last`  in  N_REQ  per-requester last beat of packet, qualified by valid
- `req_data`  in  N_REQ*FIFO_WIDTH  requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- `req_ready`  out  N_REQ  per-requester beat accepted this cycle
- `fifo_full`  in  1  FIFO `full` flag
- `fifo_wenable`  out  1  to FIFO `wenable`
- `fifo_wdata`  out  FIFO_WIDTH  to FIFO `wdata`
- `grant_id`  out  $clog2(N_REQ)  index of the current owner; registered
- `busy`  out  1  high while a grant is held (state ARB_LOCK)

## Operation
- **States:** ARB_IDLE and ARB_LOCK. Registered state: `rr_ptr`, `grant_id`, `beat_cnt` (8 bits).
- **ARB_IDLE:**
  - Search `req_valid` starting at `rr_ptr`, wrapping modulo N_REQ; the first valid requester wins.
  - On a hit, at the next edge: `grant_id` takes the winner, `beat_cnt` takes 0, and the state moves to ARB_LOCK.
  - No beat is accepted in ARB_IDLE; all `req_ready` are 0.
- **ARB_LOCK, with g = `grant_id`:**
  - `req_ready[g] = !fifo_full`; every other `req_ready` is 0.
  - A transfer occurs when `req_valid[g] && req_ready[g]`.
  - `fifo_wenable` = transfer, combinational. `fifo_wdata` = `req_data` slice g.
  - Each transfer increments `beat_cnt`.
- **Release:** a transfer with `req_last[g]=1`, or a transfer that makes `beat_cnt` reach MAX_BEATS. At that edge: state moves to ARB_IDLE and `rr_ptr` takes (g+1) mod N_REQ.
- **Idle owner:** if `req_valid[g]` drops mid-packet, the lock is held and nothing is written. No timeout.
- **Full:** `fifo_wenable` is never 1 while `fifo_full` is 1. The beat stays pending at the requester, and its data is not consumed.
- **Forced release:** the packet remainder is re-arbitrated as a new packet; the FIFO sees no marker.
- **`fifo_wdata`:** 0 in ARB_IDLE.
- **Ignored inputs:** `req_last` of non-owners has no effect.

## Timing
- **Reset values:** state ARB_IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `busy`=0, `req_ready`=0, `fifo_wenable`=0, `fifo_wdata`=0.
- **Arbitration latency:** valid seen in ARB_IDLE in cycle n means grant at edge n+1, and the first beat can transfer in cycle n+1.
- **Throughput:** within a packet, 1 beat per cycle while not full. There is exactly one idle cycle between consecutive grants.
- **Full path:** `fifo_full` to `req_ready`/`fifo_wenable` is combinational, with zero-cycle backpressure. When full deasserts in cycle n, the beat writes at edge n+1.
- **Simultaneous request and release:** a request from another requester in the release cycle is arbitrated in the following ARB_IDLE cycle, using the updated `rr_ptr`.
- **Reset mid-packet:** `rst` in ARB_LOCK aborts the grant at that edge. Beats already written stay in the FIFO; no partial-packet cleanup is done.

## Structure
- **Package `fifo_arb_pkg`:**
  - `arb_state_t` enum {ARB_IDLE, ARB_LOCK}
  - `BEAT_CNT_W` = 8
  - function `id_width(n)` returning max(1, $clog2(n))
- **Sub-module `rr_pick`:** combinational rotate-priority search. Inputs are `req` [N_REQ] and `ptr`; outputs are `hit` and `idx`.
- **Top-level tie-off:** the FIFO is instantiated by the parent, not inside the arbiter.

## Test plan
All scenarios use N_REQ=4, FIFO_WIDTH=8, MAX_BEATS=8, with the arbiter driving a FIFO of depth 16.

- **Reset:** `rst`=1 for 2 cycles with random requests → all outputs 0, `busy`=0, FIFO `empty`=1.
- **Single packet:** requester 1 sends 0x11, 0x12, 0x13 with `last` on 0x13 → `grant_id`=1 one cycle after valid; 3 consecutive `fifo_wenable` cycles; `busy` falls after 0x13; FIFO pops 0x11, 0x12, 0x13.
- **Round-robin order:** all 4 requesters each hold a 1-beat packet (0xA0 + i) after reset → FIFO order 0xA0, 0xA1, 0xA2, 0xA3. Re-offering requester 0 afterwards wins again.
- **Backpressure:** requester 2 writes 17 beats 0x00..0x10 in packets of 8, 8 and 1 → after 16 beats `fifo_full`=1, `req_ready[2]`=0, `fifo_wenable`=0. One FIFO pop lets 0x10 write the next cycle. Pops return 0x00..0x10 in order.
- **Forced release:** requester 3 streams 10 beats with no `last`, and requester 0 holds a 1-beat packet 0x55 → the grant releases after 8 beats; 0x55 is written next, then requester 3's remaining 2 beats.
- **Reset mid-packet:** assert `rst` after 2 beats of a 4-beat packet from requester 1 → next cycle `busy`=0, `req_ready`=0, `rr_ptr`=0, and the FIFO holds exactly 2 entries.
